// File: rtl/coffee_pkg.sv
// Shared coffee-maker definitions: ingredient codes, timer state encoding,
// valve bit positions and small decode helpers used by the dispensing stage.
package coffee_pkg;

  localparam logic [2:0] ING_AGUA      = 3'd0;
  localparam logic [2:0] ING_CAFE      = 3'd1;
  localparam logic [2:0] ING_LECHE     = 3'd2;
  localparam logic [2:0] ING_CHOCOLATE = 3'd3;
  localparam logic [2:0] ING_AZUCAR    = 3'd4;

  localparam int VALVE_AGUA      = 0;
  localparam int VALVE_CAFE      = 1;
  localparam int VALVE_LECHE     = 2;
  localparam int VALVE_CHOCOLATE = 3;
  localparam int VALVE_AZUCAR    = 4;
  localparam int VALVE_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_t;

  function automatic logic ing_valid(input logic [2:0] code);
    return code <= ING_AZUCAR;
  endfunction

  // Durations are 8-bit tick counts; a zero duration would never expire, so it becomes 1.
  function automatic logic [7:0] dur_ticks(input int d);
    logic [7:0] t;
    t = 8'(d);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

  function automatic logic [VALVE_W-1:0] valve_decode(input logic [2:0] code);
    logic [VALVE_W-1:0] v;
    v = '0;
    case (code)
      ING_AGUA:      v[VALVE_AGUA]      = 1'b1;
      ING_CAFE:      v[VALVE_CAFE]      = 1'b1;
      ING_LECHE:     v[VALVE_LECHE]     = 1'b1;
      ING_CHOCOLATE: v[VALVE_CHOCOLATE] = 1'b1;
      ING_AZUCAR:    v[VALVE_AZUCAR]    = 1'b1;
      default:       v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ingredient_timer_if.sv
// Recipe FSM <-> ingredient timer handshake: start/code/abort requests and
// the timer's status, valve and countdown outputs.
interface ingredient_timer_if;
  import coffee_pkg::*;

  logic               star_timer;
  logic [2:0]         ing_type;
  logic               abort;
  logic               t_expired;
  logic               busy;
  logic [VALVE_W-1:0] valve;
  logic [7:0]         remaining;
  logic               bad_ing;

  modport master (
    output star_timer, ing_type, abort,
    input  t_expired, busy, valve, remaining, bad_ing
  );

  modport slave (
    input  star_timer, ing_type, abort,
    output t_expired, busy, valve, remaining, bad_ing
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter that produces one dispense tick per wrap.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  assign tick = en && (count_q == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tick ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/ingredient_timer.sv
// Dispensing stage: opens one valve per ingredient for a fixed number of
// prescaled ticks and reports completion back to the recipe FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a start with a valid ingredient code
//   RUN     | valve open, remaining counts down once per tick
//   DONE    | dispense finished, t_expired issued, back to IDLE
module ingredient_timer
  import coffee_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int DUR_AGUA      = 40,
  parameter int DUR_CAFE      = 10,
  parameter int DUR_LECHE     = 15,
  parameter int DUR_CHOCOLATE = 12,
  parameter int DUR_AZUCAR    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  ingredient_timer_if.slave  tif
);

  localparam logic [7:0] D_AGUA      = dur_ticks(DUR_AGUA);
  localparam logic [7:0] D_CAFE      = dur_ticks(DUR_CAFE);
  localparam logic [7:0] D_LECHE     = dur_ticks(DUR_LECHE);
  localparam logic [7:0] D_CHOCOLATE = dur_ticks(DUR_CHOCOLATE);
  localparam logic [7:0] D_AZUCAR    = dur_ticks(DUR_AZUCAR);

  timer_state_t       state_q, state_d;
  logic [2:0]         code_q;
  logic [7:0]         rem_q;
  logic [7:0]         dur_sel;
  logic               start_ok;
  logic               run_en;
  logic               abort_run;
  logic               tick;
  logic               t_exp_q, busy_q, bad_q;
  logic [VALVE_W-1:0] valve_q;

  always_comb begin
    dur_sel = 8'd0;
    case (tif.ing_type)
      ING_AGUA:      dur_sel = D_AGUA;
      ING_CAFE:      dur_sel = D_CAFE;
      ING_LECHE:     dur_sel = D_LECHE;
      ING_CHOCOLATE: dur_sel = D_CHOCOLATE;
      ING_AZUCAR:    dur_sel = D_AZUCAR;
      default:       dur_sel = 8'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tif.star_timer && ing_valid(tif.ing_type)) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tif.abort)                     state_d = ST_IDLE;
        else if (tick && rem_q == 8'd1)    state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_en    = (state_q == ST_RUN);
  assign abort_run = run_en && tif.abort;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (run_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= ING_AGUA;
      rem_q  <= 8'd0;
    end else if (start_ok) begin
      code_q <= tif.ing_type;
      rem_q  <= dur_sel;
    end else if (abort_run) begin
      rem_q  <= 8'd0;
    end else if (run_en && tick && rem_q != 8'd0) begin
      rem_q  <= rem_q - 8'd1;
    end
  end

  // Status outputs lag the state by one edge; abort clears them on the same edge it takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_exp_q <= 1'b0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
      valve_q <= '0;
    end else begin
      t_exp_q <= (state_q == ST_DONE);
      busy_q  <= (run_en && !tif.abort) || (state_q == ST_DONE);
      bad_q   <= (state_q == ST_IDLE) && tif.star_timer && !ing_valid(tif.ing_type);
      valve_q <= (run_en && !tif.abort) ? valve_decode(code_q) : '0;
    end
  end

  assign tif.t_expired = t_exp_q;
  assign tif.busy      = busy_q;
  assign tif.bad_ing   = bad_q;
  assign tif.valve     = valve_q;
  assign tif.remaining = rem_q;

endmodule

// File: tb/tb_ingredient_timer.sv
// Self-checking bench for ingredient_timer: edge-indexed dispense model,
// per-cycle comparison, directed scenarios and a randomized phase.
module tb_ingredient_timer;
  import coffee_pkg::*;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ingredient_timer_if tif();

  ingredient_timer #(
    .TICK_DIV   (TD),
    .DUR_CAFE   (10),
    .DUR_AZUCAR (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int tcnt = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  function automatic int model_dur(input int code);
    int d;
    case (code)
      0: d = 40;
      1: d = 10;
      2: d = 15;
      3: d = 12;
      4: d = 5;
      default: d = 0;
    endcase
    d = d % 256;
    return (d == 0) ? 1 : d;
  endfunction

  // Model: a dispense accepted at edge n with duration d occupies edges n..n+d*TD+1.
  int e = 0;
  int ready_edge = 0;
  int bad_edge = -1;
  int m_n = 0;
  int m_d = 0;
  int m_code = 0;
  bit m_active = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   = 1'b0;
      ready_edge = 0;
      bad_edge   = -1;
    end else begin
      e = e + 1;
      if (m_active && (e - m_n) >= 1 && (e - m_n) <= m_d * TD && tif.abort) begin
        m_active   = 1'b0;
        ready_edge = e + 1;
      end else if (e >= ready_edge && tif.star_timer) begin
        if (int'(tif.ing_type) <= 4) begin
          m_active   = 1'b1;
          m_n        = e;
          m_code     = int'(tif.ing_type);
          m_d        = model_dur(m_code);
          ready_edge = m_n + m_d * TD + 2;
        end else begin
          bad_edge = e;
        end
      end
    end
  end

  always @(negedge clk) begin
    int k, len, x_valve, x_busy, x_t, x_rem, x_bad;
    if (tif.t_expired) tcnt++;
    if (chk_en) begin
      x_valve = 0; x_busy = 0; x_t = 0; x_rem = 0;
      if (m_active) begin
        k   = e - m_n;
        len = m_d * TD;
        if (k >= 1 && k <= len) begin
          x_valve = 1 << m_code;
          x_busy  = 1;
        end
        if (k == len + 1) begin
          x_t    = 1;
          x_busy = 1;
        end
        if (k >= 0 && k <= len) x_rem = m_d - k / TD;
      end
      x_bad = (e == bad_edge) ? 1 : 0;
      check("cyc_valve",     int'(tif.valve),     x_valve);
      check("cyc_busy",      int'(tif.busy),      x_busy);
      check("cyc_t_expired", int'(tif.t_expired), x_t);
      check("cyc_remaining", int'(tif.remaining), x_rem);
      check("cyc_bad_ing",   int'(tif.bad_ing),   x_bad);
    end
  end

  // Called just after a negedge; returns just after the edge that sampled the start.
  task automatic start(input logic [2:0] code);
    tif.star_timer = 1'b1;
    tif.ing_type   = code;
    @(negedge clk);
    tif.star_timer = 1'b0;
    tif.ing_type   = 3'($urandom_range(0, 7));
  endtask

  // Start, measure how many sampled cycles the valve stays open, and whether t_expired follows.
  task automatic dispense(input logic [2:0] code, output int width, output int vseen, output int tseen);
    start(code);
    @(negedge clk);
    vseen = int'(tif.valve);
    width = 0;
    while (tif.valve != '0 && width < 400) begin
      width++;
      @(negedge clk);
    end
    tseen = int'(tif.t_expired);
    @(negedge clk);
  endtask

  initial begin
    int w, v, t, base;
    int exp_w[5];
    logic [4:0] one;
    exp_w = '{160, 40, 60, 48, 20};
    tif.star_timer = 1'b0;
    tif.ing_type   = 3'd0;
    tif.abort      = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valve", int'(tif.valve), 0);
    check("rst_busy", int'(tif.busy), 0);
    check("rst_remaining", int'(tif.remaining), 0);
    check("rst_t_expired", int'(tif.t_expired), 0);
    check("rst_bad_ing", int'(tif.bad_ing), 0);
    repeat (5) @(negedge clk);

    // Single CAFE dispense with literal timing
    start(3'b001);
    @(negedge clk);
    check("cafe_valve", int'(tif.valve), 5'b00010);
    check("cafe_remaining", int'(tif.remaining), 10);
    w = 0;
    while (tif.valve != '0 && w < 400) begin
      w++;
      @(negedge clk);
    end
    check("cafe_width", w, 40);
    check("cafe_t_expired", int'(tif.t_expired), 1);
    check("cafe_busy_in_done", int'(tif.busy), 1);
    @(negedge clk);
    check("cafe_t_single", int'(tif.t_expired), 0);
    check("cafe_busy_low", int'(tif.busy), 0);

    // Full recipe, each start on the first busy-low cycle
    base = tcnt;
    for (int c = 0; c < 5; c++) begin
      dispense(3'(c), w, v, t);
      one = 5'b00001 << c;
      check("recipe_valve", v, int'(one));
      check("recipe_width", w, exp_w[c]);
      check("recipe_t", t, 1);
    end
    check("recipe_pulses", tcnt - base, 5);

    // Invalid code
    tif.star_timer = 1'b1;
    tif.ing_type   = 3'b110;
    @(negedge clk);
    tif.star_timer = 1'b0;
    check("bad_pulse", int'(tif.bad_ing), 1);
    check("bad_busy", int'(tif.busy), 0);
    check("bad_valve", int'(tif.valve), 0);
    @(negedge clk);
    check("bad_single", int'(tif.bad_ing), 0);

    // Start during RUN is ignored
    base = tcnt;
    start(3'b100);
    @(negedge clk);
    repeat (4) @(negedge clk);
    tif.star_timer = 1'b1;
    tif.ing_type   = 3'b000;
    @(negedge clk);
    tif.star_timer = 1'b0;
    repeat (14) @(negedge clk);
    check("ign_valve", int'(tif.valve), 5'b10000);
    @(negedge clk);
    check("ign_t", int'(tif.t_expired), 1);
    check("ign_valve_off", int'(tif.valve), 0);
    repeat (10) @(negedge clk);
    check("ign_no_water", int'(tif.valve), 0);
    check("ign_idle", int'(tif.busy), 0);
    check("ign_pulses", tcnt - base, 1);

    // Abort mid-run
    base = tcnt;
    start(3'b001);
    @(negedge clk);
    repeat (6) @(negedge clk);
    tif.abort = 1'b1;
    @(negedge clk);
    tif.abort = 1'b0;
    check("abort_valve", int'(tif.valve), 0);
    check("abort_busy", int'(tif.busy), 0);
    check("abort_remaining", int'(tif.remaining), 0);
    repeat (50) @(negedge clk);
    check("abort_no_t", tcnt - base, 0);
    dispense(3'b001, w, v, t);
    check("abort_restart_width", w, 40);
    check("abort_restart_t", t, 1);

    // Reset mid-run
    base = tcnt;
    start(3'b001);
    @(negedge clk);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstrun_valve", int'(tif.valve), 0);
    check("rstrun_busy", int'(tif.busy), 0);
    check("rstrun_remaining", int'(tif.remaining), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rstrun_no_t", tcnt - base, 0);
    dispense(3'b001, w, v, t);
    check("rstrun_restart_width", w, 40);
    check("rstrun_restart_t", t, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      tif.star_timer = ($urandom_range(0, 3) == 0);
      tif.ing_type   = 3'($urandom_range(0, 7));
      tif.abort      = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    tif.star_timer = 1'b0;
    tif.abort      = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
